// File: rtl/mem_bus_unit.sv
// Memory bus unit: owns PC and AR, converts single-cycle read/write strobes into a
// req/ack memory handshake with wait states, timeout detection and a stall to control.
`ifndef AR_READ_PC
`define AR_READ_PC      3'd0
`endif
`ifndef AR_READ_DST_REG
`define AR_READ_DST_REG 3'd1
`endif

module mem_bus_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_i,
  input  logic              write_i,
  input  logic              ar_load_i,
  input  logic [2:0]        ar_sel_i,
  input  logic              pc_read_i,
  input  logic              pc_inc_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] addr_bus_o,
  output logic [DATA_W-1:0] ext_data_bus_o,
  output logic              stall_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_src;
  logic [ADDR_W-1:0] access_addr;

  // Unknown ar_sel codes fall back to the PC, as does an explicit pc_read.
  assign addr_src    = (pc_read_i || (ar_sel_i != `AR_READ_DST_REG)) ? pc_q : dst_addr_i;
  assign access_addr = ar_load_i ? addr_src : ar_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ar_q        <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ar_q        <= ar_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ar_d        = ar_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    stall_o     = 1'b0;
    bus_err_o   = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;

    case (state_q)
      IDLE: begin
        // A new access defers PC/AR updates until the DONE edge.
        if (read_i || write_i) begin
          stall_o     = 1'b1;
          mem_addr_d  = access_addr;
          mem_wdata_d = wdata_i;
          wr_d        = write_i;
          cnt_d       = '0;
          state_d     = ACCESS;
        end else begin
          if (pc_inc_i) pc_d = pc_q + ADDR_W'(1);
          if (ar_load_i) ar_d = addr_src;
        end
      end

      ACCESS: begin
        stall_o  = 1'b1;
        mem_wr_o = wr_q;
        mem_rd_o = !wr_q;
        if (mem_ack_i) begin
          if (!wr_q) rdata_d = mem_rdata_i;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_o = 1'b1;
          if (!wr_q) rdata_d = '1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Strobes still held by control here complete the finished command.
        if (pc_inc_i) pc_d = pc_q + ADDR_W'(1);
        if (ar_load_i) ar_d = mem_addr_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign pc_o           = pc_q;
  assign addr_bus_o     = ar_q;
  assign ext_data_bus_o = rdata_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule
